switch_input_port: RTL and testbench

Debounced, handshaked input peripheral: the read-side counterpart of the LED output port. It synchronizes and debounces the 16 board switches and the confirm button. On each confirmed button press it captures the switch word into a holding register and raises a valid flag. The CPU reads the word through the IORead/switch-select path, and that read consumes the flag. It sits between the board pins and the MemOrIO read-data mux, replacing the purely combinational switch read.

---
 rtl/switch_input_port.sv | 109 ++++++++++
 tb/tb_switch_input_port.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/switch_input_port.sv
// Debounced, handshaked switch/button input port: captures the switch word on each
// confirmed press and hands it to the CPU through a consume-on-read data register.
module switch_input_port #(
  parameter int DB_CYCLES = 200000,
  parameter int CNT_W     = 18
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] switches,
  input  logic        confirm_button,
  input  logic        ior,
  input  logic        switchctrl,
  input  logic [1:0]  addr,
  output logic [15:0] io_rdata,
  output logic        data_valid,
  output logic        overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [15:0]      sw_s1, sw_s2, sw_s3, db_sw, data_reg;
  logic             bt_s1, bt_s2, bt_s3, db_btn;
  logic [CNT_W-1:0] sw_cnt, bt_cnt;
  logic             sw_settling, bt_settling, btn_press, consume;

  // NOTE: every clocked block uses non-blocking assignments so all registers see
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      sw_s3 <= '0;
      bt_s1 <= 1'b0;
      bt_s2 <= 1'b0;
      bt_s3 <= 1'b0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
      sw_s3 <= sw_s2;
      bt_s1 <= confirm_button;
      bt_s2 <= bt_s1;
      bt_s3 <= bt_s2;
    end
  end

  // A counter only runs while the synchronized value is steady and differs from db.
  assign sw_settling = (sw_s2 == sw_s3) && (sw_s2 != db_sw);
  assign bt_settling = (bt_s2 == bt_s3) && (bt_s2 != db_btn);
  assign btn_press   = bt_settling && (bt_cnt == CNT_MAX) && bt_s2;
  assign consume     = ior && switchctrl && (addr == 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_cnt <= '0;
      db_sw  <= '0;
    end else if (!sw_settling) begin
      sw_cnt <= '0;
    end else if (sw_cnt == CNT_MAX) begin
      db_sw  <= sw_s2;
      sw_cnt <= '0;
    end else begin
      sw_cnt <= sw_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bt_cnt <= '0;
      db_btn <= 1'b0;
    end else if (!bt_settling) begin
      bt_cnt <= '0;
    end else if (bt_cnt == CNT_MAX) begin
      db_btn <= bt_s2;
      bt_cnt <= '0;
    end else begin
      bt_cnt <= bt_cnt + CNT_W'(1);
    end
  end

  // A capture at the same edge as a consume wins: the new word stays valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_reg   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (btn_press) begin
      data_reg   <= db_sw;
      data_valid <= 1'b1;
      overrun    <= consume ? 1'b0 : (overrun || data_valid);
    end else if (consume) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  // NOTE: default assignment first so the combinational read mux never infers a latch.
  always_comb begin
    io_rdata = '0;
    if (ior && switchctrl) begin
      case (addr)
        2'b00:   io_rdata = data_reg;
        2'b01:   io_rdata = {14'b0, overrun, data_valid};
        2'b10:   io_rdata = db_sw;
        default: io_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with DB_CYCLES=4; inputs change and outputs
// are sampled on the falling edge, away from the active rising edge.
module tb_switch_input_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic        confirm_button;
  logic        ior;
  logic        switchctrl;
  logic [1:0]  addr;
  logic [15:0] io_rdata;
  logic        data_valid;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  switch_input_port #(.DB_CYCLES(4), .CNT_W(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .switches       (switches),
    .confirm_button (confirm_button),
    .ior            (ior),
    .switchctrl     (switchctrl),
    .addr           (addr),
    .io_rdata       (io_rdata),
    .data_valid     (data_valid),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Combinational read; when hold is set the select stays up across one rising edge.
  task automatic rd(input logic [1:0] a, input bit hold, input string tag,
                    input logic [15:0] exp);
    ior = 1'b1; switchctrl = 1'b1; addr = a;
    #1 check(tag, io_rdata, exp);
    if (hold) @(negedge clock);
    ior = 1'b0; switchctrl = 1'b0; addr = 2'b00;
  endtask

  task automatic press();
    confirm_button = 1'b1;
    cycles(10);
    confirm_button = 1'b0;
    cycles(10);
  endtask

  initial begin
    reset = 1'b1; switches = '0; confirm_button = 1'b0;
    ior = 1'b0; switchctrl = 1'b0; addr = 2'b00;
    cycles(2);

    // Reset mid-count, then re-debounce from zero
    reset = 1'b0;
    switches = 16'hFFFF;
    cycles(3);
    #2 reset = 1'b1;
    ior = 1'b1; switchctrl = 1'b1; addr = 2'b10;
    #1 check("rst_live", io_rdata, 16'h0000);
    check("rst_flags", {14'b0, overrun, data_valid}, 16'h0000);
    ior = 1'b0; switchctrl = 1'b0; addr = 2'b00;
    cycles(2);
    reset = 1'b0;
    cycles(6);
    rd(2'b10, 1'b0, "rst_live_edge6", 16'h0000);
    cycles(1);
    rd(2'b10, 1'b0, "rst_live_edge7", 16'hFFFF);

    // Basic capture
    switches = 16'hA5A5;
    cycles(10);
    confirm_button = 1'b1;
    cycles(6);
    check("cap_valid_early", {15'b0, data_valid}, 16'h0000);
    cycles(1);
    check("cap_valid", {15'b0, data_valid}, 16'h0001);
    rd(2'b01, 1'b1, "cap_status", 16'h0001);
    check("status_no_consume", {15'b0, data_valid}, 16'h0001);
    rd(2'b00, 1'b1, "cap_data", 16'hA5A5);
    check("cap_consumed", {15'b0, data_valid}, 16'h0000);
    cycles(3);
    confirm_button = 1'b0;
    cycles(10);

    // Button bounce: one capture only
    switches = 16'h0F0F;
    cycles(10);
    for (int i = 0; i < 10; i++) begin
      confirm_button = ~i[0];
      cycles(2);
    end
    check("bounce_no_cap", {15'b0, data_valid}, 16'h0000);
    confirm_button = 1'b1;
    cycles(10);
    check("bounce_flags", {14'b0, overrun, data_valid}, 16'h0001);
    rd(2'b00, 1'b1, "bounce_data", 16'h0F0F);
    confirm_button = 1'b0;
    cycles(10);

    // Short switch glitch never reaches the debounced value
    switches = 16'h0000;
    cycles(10);
    switches = 16'h0001;
    cycles(3);
    switches = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      rd(2'b10, 1'b0, "glitch_live", 16'h0000);
      cycles(1);
    end

    // Overrun
    switches = 16'h1234;
    cycles(10);
    press();
    switches = 16'h5678;
    cycles(10);
    press();
    rd(2'b01, 1'b0, "ovr_status", 16'h0003);
    rd(2'b00, 1'b1, "ovr_data", 16'h5678);
    rd(2'b01, 1'b0, "ovr_cleared", 16'h0000);

    // Simultaneous capture and consume
    switches = 16'h1111;
    cycles(10);
    press();
    switches = 16'hBEEF;
    cycles(10);
    confirm_button = 1'b1;
    cycles(6);
    rd(2'b00, 1'b1, "sim_old_data", 16'h1111);
    check("sim_flags", {14'b0, overrun, data_valid}, 16'h0001);
    rd(2'b00, 1'b0, "sim_new_data", 16'hBEEF);
    cycles(3);
    confirm_button = 1'b0;
    cycles(10);

    // Select gating leaves the flags alone
    ior = 1'b1; switchctrl = 1'b0; addr = 2'b00;
    #1 check("gate_noselect", io_rdata, 16'h0000);
    @(negedge clock);
    ior = 1'b0;
    check("gate_noselect_valid", {15'b0, data_valid}, 16'h0001);
    rd(2'b11, 1'b1, "gate_reserved", 16'h0000);
    check("gate_reserved_valid", {15'b0, data_valid}, 16'h0001);
    rd(2'b00, 1'b1, "final_data", 16'hBEEF);
    check("final_consumed", {15'b0, data_valid}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
